// File: rtl/ntt_core_seq.sv
// rtl/ntt_core_seq.sv - self-sequenced NTT processing element with ping-pong RAM
//
// Purpose: LANES butterfly lanes fed from per-lane ping-pong coefficient RAMs.
//   A start pulse runs one stage. The stage reads every word of the read page,
//   fetches a twiddle per lane, applies a CT (forward) or GS (inverse) butterfly
//   mod MODULUS, and streams the results out in address order. done pulses once
//   after the last beat has been emitted.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             one-cycle stage launch (IDLE only)
//   log_m, inverse,   stage configuration, latched at start
//   tw_mode, grp
//   swap              flip read/write pages (IDLE only)
//   wr_en/addr/data   per-lane preload/writeback into the write page
//   tw_idx / tw_data  per-lane twiddle ROM address out / value in (same cycle)
//   busy, done        stage status
//   res_valid/addr/data  result stream, per-lane {B,A}
module ntt_core_seq #(
  parameter int DATA_W         = 30,
  parameter int MODULUS        = 1068564481,
  parameter int LANES          = 2,
  parameter int LOG_DEPTH      = 9,
  parameter int BF_LAT         = 4,
  parameter int TW_W           = 12,
  parameter int CORE_INDEX     = 0,
  parameter int LOG_CORE_COUNT = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [3:0]                    log_m,
  input  logic                          inverse,
  input  logic [1:0]                    tw_mode,
  input  logic [LOG_DEPTH:0]            grp,
  input  logic                          swap,
  input  logic [LANES-1:0]              wr_en,
  input  logic [LANES*LOG_DEPTH-1:0]    wr_addr,
  input  logic [LANES*2*DATA_W-1:0]     wr_data,
  output logic [LANES*TW_W-1:0]         tw_idx,
  input  logic [LANES*DATA_W-1:0]       tw_data,
  output logic                          busy,
  output logic                          done,
  output logic                          res_valid,
  output logic [LOG_DEPTH-1:0]          res_addr,
  output logic [LANES*2*DATA_W-1:0]     res_data
);

  localparam int DEPTH = 1 << LOG_DEPTH;
  localparam int DW2   = 2 * DATA_W;
  localparam logic [DW2-1:0]    QP = DW2'(MODULUS);
  localparam logic [DATA_W-1:0] QD = DATA_W'(MODULUS);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                 r_state;
  logic                   r_rd_page;
  logic                   r_busy;
  logic                   r_done;
  logic [LOG_DEPTH-1:0]   r_addr;
  logic [3:0]             r_log_m;
  logic                   r_inverse;
  logic [1:0]             r_tw_mode;
  logic [LOG_DEPTH:0]     r_grp;

  // Stage 0 holds the registered RAM word / twiddle; r_p* is the butterfly pipe.
  logic                   r_s0_valid;
  logic [LOG_DEPTH-1:0]   r_s0_addr;
  logic [BF_LAT-1:0]      r_pv;
  logic [LOG_DEPTH-1:0]   r_pa [BF_LAT];
  logic [LANES*DW2-1:0]   r_pd [BF_LAT];

  logic [LANES*DW2-1:0]   w_bf;
  logic [31:0]            w_base;
  logic                   w_drained;

  function automatic logic [DATA_W-1:0] mod_add(input logic [DATA_W-1:0] x,
                                                 input logic [DATA_W-1:0] y);
    logic [DATA_W:0] s;
    s = {1'b0, x} + {1'b0, y};
    return (s >= {1'b0, QD}) ? DATA_W'(s - {1'b0, QD}) : DATA_W'(s);
  endfunction

  // Wrap-around in DATA_W bits is exact here because the true result is < Q.
  function automatic logic [DATA_W-1:0] mod_sub(input logic [DATA_W-1:0] x,
                                                 input logic [DATA_W-1:0] y);
    return (x >= y) ? (x - y) : (x + QD - y);
  endfunction

  assign w_base = (32'd1 << r_log_m)
                + ((32'(CORE_INDEX) << r_log_m) >> LOG_CORE_COUNT);

  // Last beat is on the output and nothing is left behind it.
  assign w_drained = ({r_pv, r_s0_valid} == {1'b1, {BF_LAT{1'b0}}});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_rd_page <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_addr    <= '0;
      r_log_m   <= '0;
      r_inverse <= 1'b0;
      r_tw_mode <= '0;
      r_grp     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // swap first, so a simultaneous start reads the new page
          if (swap) r_rd_page <= ~r_rd_page;
          if (start) begin
            r_log_m   <= log_m;
            r_inverse <= inverse;
            r_tw_mode <= tw_mode;
            r_grp     <= grp;
            r_addr    <= '0;
            r_busy    <= 1'b1;
            r_state   <= S_RUN;
          end
        end
        S_RUN: begin
          if (r_addr == LOG_DEPTH'(DEPTH - 1)) r_state <= S_DRAIN;
          r_addr <= r_addr + 1'b1;
        end
        S_DRAIN: begin
          if (w_drained) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s0_valid <= 1'b0;
      r_s0_addr  <= '0;
      r_pv       <= '0;
      for (int i = 0; i < BF_LAT; i++) begin
        r_pa[i] <= '0;
        r_pd[i] <= '0;
      end
    end else begin
      r_s0_valid <= (r_state == S_RUN);
      r_s0_addr  <= r_addr;
      r_pv[0]    <= r_s0_valid;
      r_pa[0]    <= r_s0_addr;
      r_pd[0]    <= w_bf;
      for (int i = 1; i < BF_LAT; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pa[i] <= r_pa[i-1];
        r_pd[i] <= r_pd[i-1];
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [DW2-1:0]    r_ram [2*DEPTH];
    logic [DW2-1:0]    r_word;
    logic [DATA_W-1:0] r_w;
    logic [DATA_W-1:0] w_a, w_b, w_mul_in, w_red, w_res_a, w_res_b;
    logic [DW2-1:0]    w_prod;
    logic [31:0]       w_off;

    // RAM address is {page, word}; writes always land on the page not being read.
    always_ff @(posedge clk) begin
      if (wr_en[l])
        r_ram[{~r_rd_page, wr_addr[l*LOG_DEPTH +: LOG_DEPTH]}] <= wr_data[l*DW2 +: DW2];
      r_word <= r_ram[{r_rd_page, r_addr}];
      r_w    <= tw_data[l*DATA_W +: DATA_W];
    end

    assign w_a      = r_word[DATA_W-1:0];
    assign w_b      = r_word[DW2-1:DATA_W];
    // CT multiplies b by w; GS multiplies (a-b) by w. One multiplier serves both.
    assign w_mul_in = r_inverse ? mod_sub(w_a, w_b) : w_b;
    assign w_prod   = {{DATA_W{1'b0}}, w_mul_in} * {{DATA_W{1'b0}}, r_w};
    assign w_red    = DATA_W'(w_prod % QP);
    assign w_res_a  = mod_add(w_a, r_inverse ? w_b : w_red);
    assign w_res_b  = r_inverse ? w_red : mod_sub(w_a, w_red);
    assign w_bf[l*DW2 +: DW2] = {w_res_b, w_res_a};

    always_comb begin
      w_off = 32'd0;
      case (r_tw_mode)
        2'd1:    w_off = 32'(LANES) * 32'(r_grp) + 32'(l);
        2'd2:    w_off = 32'(LANES) * 32'(r_addr) + 32'(l);
        default: w_off = 32'd0;
      endcase
    end

    assign tw_idx[l*TW_W +: TW_W] = TW_W'(w_base + w_off);
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign res_valid = r_pv[BF_LAT-1];
  assign res_addr  = r_pa[BF_LAT-1];
  assign res_data  = r_pd[BF_LAT-1];

endmodule

// File: tb/tb_ntt_core_seq.sv
// tb/tb_ntt_core_seq.sv - directed bench for ntt_core_seq (Q=17, 2 lanes, 8 words)
module tb_ntt_core_seq;

  localparam int DATA_W = 5;
  localparam int LANES  = 2;
  localparam int LOG_D  = 3;
  localparam int NW     = 1 << LOG_D;
  localparam int BF_LAT = 4;
  localparam int TW_W   = 12;

  logic                        clk = 1'b0;
  logic                        rst = 1'b1;
  logic                        start = 1'b0;
  logic [3:0]                  log_m = '0;
  logic                        inverse = 1'b0;
  logic [1:0]                  tw_mode = '0;
  logic [LOG_D:0]              grp = '0;
  logic                        swap = 1'b0;
  logic [LANES-1:0]            wr_en = '0;
  logic [LANES*LOG_D-1:0]      wr_addr = '0;
  logic [LANES*2*DATA_W-1:0]   wr_data = '0;
  logic [LANES*TW_W-1:0]       tw_idx;
  logic [LANES*DATA_W-1:0]     tw_data = {5'd16, 5'd2};
  logic                        busy, done, res_valid;
  logic [LOG_D-1:0]            res_addr;
  logic [LANES*2*DATA_W-1:0]   res_data;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int wa [LANES][NW];
  int wb [LANES][NW];
  int tw [LANES];

  ntt_core_seq #(
    .DATA_W(DATA_W), .MODULUS(17), .LANES(LANES), .LOG_DEPTH(LOG_D),
    .BF_LAT(BF_LAT), .TW_W(TW_W), .CORE_INDEX(3), .LOG_CORE_COUNT(5)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .log_m(log_m), .inverse(inverse),
    .tw_mode(tw_mode), .grp(grp), .swap(swap), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .tw_idx(tw_idx), .tw_data(tw_data), .busy(busy), .done(done),
    .res_valid(res_valid), .res_addr(res_addr), .res_data(res_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference butterfly on plain integers, packed {B,A}.
  function automatic logic [9:0] ref_bf(input int a, input int b, input int w, input bit inv);
    int ra, rb;
    if (!inv) begin
      ra = (a + w * b) % 17;
      rb = (((a - w * b) % 17) + 17) % 17;
    end else begin
      ra = (a + b) % 17;
      rb = (((((a - b) % 17) + 17) % 17) * w) % 17;
    end
    return {5'(rb), 5'(ra)};
  endfunction

  task automatic run_stage(input bit inv, input bit sw, input logic [3:0] lm,
                           input logic [1:0] md, input logic [LOG_D:0] g,
                           input int tw_at, input int tw0, input int tw1, input bit poke);
    int c0, nb, nd, cd;
    logic [9:0] e0, e1;
    inverse = inv; swap = sw; log_m = lm; tw_mode = md; grp = g;
    start = 1'b1;
    c0 = cyc;
    tick();
    start = 1'b0; swap = 1'b0;
    check("busy_after_start", 64'(busy), 64'(1));
    nb = 0; nd = 0; cd = -1;
    for (int i = 1; i < 22; i++) begin
      if (cyc - c0 == tw_at) begin
        check("tw_idx_lane0", 64'(tw_idx[TW_W-1:0]), 64'(tw0));
        check("tw_idx_lane1", 64'(tw_idx[2*TW_W-1:TW_W]), 64'(tw1));
      end
      if (res_valid) begin
        check("beat_addr", 64'(res_addr), 64'(nb));
        if (nb < NW) begin
          e0 = ref_bf(wa[0][nb], wb[0][nb], tw[0], inv);
          e1 = ref_bf(wa[1][nb], wb[1][nb], tw[1], inv);
          check("beat_data", 64'(res_data), 64'({e1, e0}));
        end
        if (nb == 0)
          check("hand_lane0_a3_b5_w2", 64'(res_data[9:0]),
                inv ? 64'({5'd13, 5'd8}) : 64'({5'd10, 5'd13}));
        if (nb == 1)
          check("edge_lane1_q1", 64'(res_data[19:10]),
                inv ? 64'({5'd0, 5'd15}) : 64'({5'd15, 5'd0}));
        nb++;
      end
      if (done) begin
        nd++;
        cd = cyc - c0;
      end
      // While busy: a second start and a swap must both be ignored.
      start   = poke && (i == 3);
      inverse = (poke && (i == 3)) ? ~inv : inv;
      swap    = poke && (i == 4);
      tick();
    end
    check("beat_count", 64'(nb), 64'(NW));
    check("done_pulses", 64'(nd), 64'(1));
    check("start_to_done", 64'(cd), 64'(NW + BF_LAT + 2));
    check("busy_after_done", 64'(busy), 64'(0));
  endtask

  initial begin
    int found, nd, nb;
    tw[0] = 2;
    tw[1] = 16;
    for (int k = 0; k < NW; k++) begin
      wa[0][k] = (k * 3) % 17;
      wb[0][k] = (k * 5 + 1) % 17;
      wa[1][k] = (k + 9) % 17;
      wb[1][k] = 16 - k;
    end
    wa[0][0] = 3;  wb[0][0] = 5;
    wa[1][1] = 16; wb[1][1] = 16;
    wa[0][7] = 16; wb[0][7] = 16;

    rst = 1'b1;
    tick(); tick(); tick();
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_res_valid", 64'(res_valid), 64'(0));
    check("rst_res_addr", 64'(res_addr), 64'(0));
    check("rst_res_data", 64'(res_data), 64'(0));
    rst = 1'b0;
    tick();

    // Preload the write page (page 1), then make it the read page.
    for (int k = 0; k < NW; k++) begin
      wr_en   = 2'b11;
      wr_addr = {3'(k), 3'(k)};
      wr_data = {5'(wb[1][k]), 5'(wa[1][k]), 5'(wb[0][k]), 5'(wa[0][k])};
      tick();
    end
    wr_en = '0;
    swap = 1'b1;
    tick();
    swap = 1'b0;
    tick();

    // CT, per-word twiddles: addr 5 issued 6 cycles after start -> 64+6+10+L.
    run_stage(1'b0, 1'b0, 4'd6, 2'd2, '0, 6, 80, 81, 1'b1);
    // GS, per-group twiddles, same page (the swap during RUN must not have applied).
    run_stage(1'b1, 1'b0, 4'd3, 2'd1, 4'd2, 2, 12, 13, 1'b0);

    // Reset during RUN at beat 2.
    inverse = 1'b0; tw_mode = 2'd0; log_m = 4'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    found = 0;
    for (int i = 0; i < 30 && found == 0; i++) begin
      if (res_valid && res_addr == 3'd2) found = 1;
      else tick();
    end
    check("beat2_seen", 64'(found), 64'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_res_valid", 64'(res_valid), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    nd = 0; nb = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) nd++;
      if (res_valid) nb++;
      tick();
    end
    check("midrst_no_done", 64'(nd), 64'(0));
    check("midrst_no_beats", 64'(nb), 64'(0));

    // Reset returned rd_page to 0; start+swap together must read page 1.
    run_stage(1'b0, 1'b1, 4'd0, 2'd0, '0, 3, 1, 1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
